// File: rtl/hsi_vctr_streamer_if.sv
// Element stream from the vector streamer to the MSE datapath.
// master drives one (pixel, library) word pair per cycle; slave consumes it unconditionally.
interface hsi_vctr_streamer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int REF_WIDTH  = 8
);
  logic                  element_valid;
  logic                  element_start;
  logic                  element_last;
  logic [REF_WIDTH-1:0]  vctr_ref;
  logic [WORD_WIDTH-1:0] element_a;
  logic [WORD_WIDTH-1:0] element_b;

  modport master (
    output element_valid, element_start, element_last, vctr_ref, element_a, element_b
  );

  modport slave (
    input element_valid, element_start, element_last, vctr_ref, element_a, element_b
  );
endinterface

// File: rtl/hsi_vctr_streamer.sv
// Transmit side of the MSE element stream.
// Holds one pixel vector in a word buffer and sweeps lib_size library vectors
// from a synchronous memory, pairing every library word with the matching
// pixel word and framing each vector with start/last and its library index.
// Optional feature: define HSI_STREAMER_ABORT_EN to add an abort input that
// cancels a running sweep (squashing in-flight reads) and ends it with done.
module hsi_vctr_streamer #(
  parameter  int WORD_WIDTH            = 32,
  parameter  int DATA_WIDTH            = 16,
  parameter  int HSI_BANDS             = 128,
  parameter  int HSI_LIBRARY_SIZE      = 256,
  localparam int WORDS                 = HSI_BANDS * DATA_WIDTH / WORD_WIDTH,
  localparam int WORDS_ADDR            = $clog2(WORDS),
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        pixel_wr_en,
  input  logic [WORDS_ADDR-1:0]                       pixel_wr_addr,
  input  logic [WORD_WIDTH-1:0]                       pixel_wr_data,
  input  logic                                        start,
  input  logic [HSI_LIBRARY_SIZE_ADDR:0]              lib_size,
`ifdef HSI_STREAMER_ABORT_EN
  input  logic                                        abort,
`endif
  output logic                                        busy,
  output logic                                        done,
  output logic                                        lib_rd_en,
  output logic [HSI_LIBRARY_SIZE_ADDR+WORDS_ADDR-1:0] lib_rd_addr,
  input  logic [WORD_WIDTH-1:0]                       lib_rd_data,
  hsi_vctr_streamer_if.master                         elem
);

  localparam int                       LIB_CNT_W = HSI_LIBRARY_SIZE_ADDR + 1;
  localparam logic [LIB_CNT_W-1:0]     LIB_MAX   = LIB_CNT_W'(HSI_LIBRARY_SIZE);
  localparam logic [WORDS_ADDR-1:0]    LAST_WORD = WORDS_ADDR'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                            state;
  logic                              drain_cnt;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0]  rd_vec;
  logic [WORDS_ADDR-1:0]             rd_word;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0]  last_vec;

  // Read-issue stage, aligned with lib_rd_data one cycle after the read.
  logic                              s1_valid;
  logic [WORDS_ADDR-1:0]             s1_word;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0]  s1_vec;
  logic [WORD_WIDTH-1:0]             s1_pix;

  logic [WORD_WIDTH-1:0]             pixel_buf [WORDS];
  logic [WORD_WIDTH-1:0]             pix_rd;
  logic [LIB_CNT_W-1:0]              lib_clamped;
  logic                              squash;

  assign lib_clamped = (lib_size > LIB_MAX) ? LIB_MAX : lib_size;
  assign lib_rd_addr = {rd_vec, rd_word};
  assign pix_rd      = pixel_buf[rd_word];

`ifdef HSI_STREAMER_ABORT_EN
  // The done cycle is already the end of the sweep, so abort there changes nothing.
  assign squash = abort && busy && (state != ST_DONE);
`else
  assign squash = 1'b0;
`endif

  // Pixel buffer: written only while idle so it stays stable through a sweep.
  // NOTE: storage arrays carry no reset; only control state is reset, which lets the buffer map to RAM.
  always_ff @(posedge clk) begin
    if (pixel_wr_en && (state == ST_IDLE)) begin
      pixel_buf[pixel_wr_addr] <= pixel_wr_data;
    end
  end

  // Sweep FSM, read address generation and the two-stage element pipeline.
  // NOTE: every register here uses <= so all updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      drain_cnt          <= 1'b0;
      rd_vec             <= '0;
      rd_word            <= '0;
      last_vec           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      lib_rd_en          <= 1'b0;
      s1_valid           <= 1'b0;
      s1_word            <= '0;
      s1_vec             <= '0;
      s1_pix             <= '0;
      elem.element_valid <= 1'b0;
      elem.element_start <= 1'b0;
      elem.element_last  <= 1'b0;
      elem.vctr_ref      <= '0;
      elem.element_a     <= '0;
      elem.element_b     <= '0;
    end else begin
      // Stage 1: capture the pixel word and position of the read issued this cycle.
      s1_valid <= lib_rd_en;
      s1_word  <= rd_word;
      s1_vec   <= rd_vec;
      s1_pix   <= pix_rd;

      // Stage 2: pair with the library word that arrives now; payload holds while idle.
      elem.element_valid <= s1_valid && !squash;
      elem.element_start <= s1_valid && !squash && (s1_word == '0);
      elem.element_last  <= s1_valid && !squash && (s1_word == LAST_WORD);
      if (s1_valid && !squash) begin
        elem.vctr_ref  <= s1_vec;
        elem.element_a <= s1_pix;
        elem.element_b <= lib_rd_data;
      end

      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            rd_vec   <= '0;
            rd_word  <= '0;
            last_vec <= HSI_LIBRARY_SIZE_ADDR'(lib_clamped - LIB_CNT_W'(1));
            if (lib_clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_STREAM;
              lib_rd_en <= 1'b1;
            end
          end
        end

        ST_STREAM: begin
          if ((rd_word == LAST_WORD) && (rd_vec == last_vec)) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
            lib_rd_en <= 1'b0;
          end else if (rd_word == LAST_WORD) begin
            rd_word <= '0;
            rd_vec  <= rd_vec + HSI_LIBRARY_SIZE_ADDR'(1);
          end else begin
            rd_word <= rd_word + WORDS_ADDR'(1);
          end
        end

        // Two cycles for the last read to reach the element register.
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase

      // Abort: stop reads, kill in-flight data, and finish after one empty cycle.
      if (squash) begin
        state     <= ST_DRAIN;
        drain_cnt <= 1'b1;
        lib_rd_en <= 1'b0;
        s1_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hsi_vctr_streamer.sv
// Self-checking bench for hsi_vctr_streamer.
// A reference model derives, per sweep, the expected read addresses, element
// pairs, done cycle and busy window; monitors compare against DUT outputs.
// Define HSI_STREAMER_ABORT_EN for both bench and RTL to exercise abort.
module tb_hsi_vctr_streamer;

  localparam int WORDS   = 64;
  localparam int LIB_MAX = 256;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    int          vref;
    bit          s;
    bit          l;
  } elem_t;

  typedef struct {
    int cyc;
    int addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_wr_en = 1'b0;
  logic [5:0]  pixel_wr_addr = '0;
  logic [31:0] pixel_wr_data = '0;
  logic        start = 1'b0;
  logic [8:0]  lib_size_i = '0;
  logic        abort = 1'b0;
  logic        busy, done, lib_rd_en;
  logic [13:0] lib_rd_addr;
  logic [31:0] lib_rd_data = '0;

  hsi_vctr_streamer_if #(.WORD_WIDTH(32), .REF_WIDTH(8)) elem_if ();

  hsi_vctr_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_wr_en   (pixel_wr_en),
    .pixel_wr_addr (pixel_wr_addr),
    .pixel_wr_data (pixel_wr_data),
    .start         (start),
    .lib_size      (lib_size_i),
`ifdef HSI_STREAMER_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .lib_rd_en     (lib_rd_en),
    .lib_rd_addr   (lib_rd_addr),
    .lib_rd_data   (lib_rd_data),
    .elem          (elem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Library memory: synchronous read, data one cycle after the strobe.
  logic [31:0] lib_mem [LIB_MAX*WORDS];
  always @(posedge clk) if (lib_rd_en) lib_rd_data <= lib_mem[lib_rd_addr];

  logic [31:0] pix_m [WORDS];
  elem_t       exp_q [$];
  rd_t         rd_q [$];
  int          done_q [$];
  int          busy_from = 1;
  int          busy_to = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the scoreboard.
  always @(negedge clk) begin : monitor
    elem_t e;
    rd_t   r;
    int    d;
    if (!rst) begin
      if (elem_if.element_valid) begin
        if (exp_q.size() == 0) check("elem_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("elem_cycle", cyc, e.cyc);
          check("elem_a", elem_if.element_a, e.a);
          check("elem_b", elem_if.element_b, e.b);
          check("elem_vctr_ref", elem_if.vctr_ref, e.vref);
          check("elem_start", elem_if.element_start, e.s);
          check("elem_last", elem_if.element_last, e.l);
        end
      end else begin
        check("framing_when_idle", {elem_if.element_start, elem_if.element_last}, 0);
      end
      if (lib_rd_en) begin
        if (rd_q.size() == 0) check("read_unexpected", 1, 0);
        else begin
          r = rd_q.pop_front();
          check("read_cycle", cyc, r.cyc);
          check("read_addr", lib_rd_addr, r.addr);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
      end
      check("busy", busy, (cyc >= busy_from && cyc <= busy_to));
    end
  end

  task automatic write_pix(input int w, input logic [31:0] data);
    @(posedge clk); #1;
    pixel_wr_en = 1'b1; pixel_wr_addr = 6'(w); pixel_wr_data = data;
    @(posedge clk); #1;
    pixel_wr_en = 1'b0;
    pix_m[w] = data;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_lib_rd_en"}, lib_rd_en, 0);
    check({tag, "_lib_rd_addr"}, lib_rd_addr, 0);
    check({tag, "_valid"}, elem_if.element_valid, 0);
    check({tag, "_start_last"}, {elem_if.element_start, elem_if.element_last}, 0);
    check({tag, "_vctr_ref"}, elem_if.vctr_ref, 0);
    check({tag, "_a"}, elem_if.element_a, 0);
    check({tag, "_b"}, elem_if.element_b, 0);
  endtask

  // One sweep: issue start, push model expectations, optionally poke / abort / reset mid-sweep.
  task automatic run_sweep(input int size, input bit poke, input bit wr_with_start,
                           input int abort_at, input int rst_at);
    int n, k, n_el, n_rd, done_cyc, end_cyc, wr_w;
    logic [31:0] wr_d;
    n = (size > LIB_MAX) ? LIB_MAX : size;
    @(posedge clk); #1;
    start = 1'b1; lib_size_i = 9'(size);
    if (wr_with_start) begin
      wr_w = int'($urandom_range(0, WORDS - 1)); wr_d = $urandom;
      pixel_wr_en = 1'b1; pixel_wr_addr = 6'(wr_w); pixel_wr_data = wr_d;
      pix_m[wr_w] = wr_d;
    end
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0; pixel_wr_en = 1'b0;

    n_el = n * WORDS;
    n_rd = n * WORDS;
    done_cyc = (n == 0) ? k : k + n * WORDS + 2;
    if (abort_at >= 0) begin
      n_el = abort_at + 1;
      n_rd = abort_at + 3;
      done_cyc = k + abort_at + 4;
    end
    for (int i = 0; i < n_rd; i++) rd_q.push_back('{cyc: k + i, addr: i});
    for (int i = 0; i < n_el; i++)
      exp_q.push_back('{cyc: k + 2 + i, a: pix_m[i % WORDS], b: lib_mem[i],
                        vref: i / WORDS, s: (i % WORDS) == 0, l: (i % WORDS) == WORDS - 1});
    done_q.push_back(done_cyc);
    busy_from = k;
    busy_to = done_cyc;
    end_cyc = done_cyc + 2;

    for (int c = 0; c < 20000 && cyc < end_cyc; c++) begin
      if (poke && cyc == k + 5000) begin
        start = 1'b1; lib_size_i = 9'd1;
        pixel_wr_en = 1'b1; pixel_wr_addr = 6'd3; pixel_wr_data = ~pix_m[3];
      end else begin
        start = 1'b0; pixel_wr_en = 1'b0;
      end
      abort = (abort_at >= 0 && cyc == k + 2 + abort_at);
      if (rst_at >= 0 && cyc == k + 2 + rst_at) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("midsweep_rst");
        exp_q.delete(); rd_q.delete(); done_q.delete();
        busy_from = 1; busy_to = 0;
        end_cyc = cyc + 3;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; pixel_wr_en = 1'b0; abort = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("elements_drained", exp_q.size(), 0);
    check("reads_drained", rd_q.size(), 0);
    check("done_drained", done_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < LIB_MAX * WORDS; i++) lib_mem[i] = 32'(i);
    #2;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp pixel words and address-valued library words.
    for (int w = 0; w < WORDS; w++) write_pix(w, {16'(2 * w + 1), 16'(2 * w)});
    run_sweep(1, 1'b0, 1'b0, -1, -1);
    run_sweep(3, 1'b0, 1'b0, -1, -1);
    run_sweep(0, 1'b0, 1'b0, -1, -1);
    // Oversized request clamps to the full library; mid-sweep start/write must be ignored.
    run_sweep(300, 1'b1, 1'b0, -1, -1);
    // Reset at element 100, then a clean sweep restarting from (0,0).
    run_sweep(3, 1'b0, 1'b0, -1, 100);
    run_sweep(1, 1'b0, 1'b0, -1, -1);

    // Random contents, random sizes, a pixel write coinciding with start.
    for (int i = 0; i < LIB_MAX * WORDS; i++) lib_mem[i] = $urandom;
    for (int w = 0; w < WORDS; w++) write_pix(w, $urandom);
    for (int t = 0; t < 4; t++) run_sweep(int'($urandom_range(1, 4)), 1'b0, 1'b1, -1, -1);

`ifdef HSI_STREAMER_ABORT_EN
    run_sweep(2, 1'b0, 1'b0, 70, -1);
    run_sweep(1, 1'b0, 1'b0, -1, -1);
`endif

    check("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
